// File: rtl/mbr_mem_ctrl.sv
// rtl/mbr_mem_ctrl.sv - memory buffer register with single-transfer memory-bus handshake
// Captures ACC on write or memory data on read; buffer feeds ALU, IR opcode and MAR fields.
module mbr_mem_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] from_ACC,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] to_ALU,
    output logic [7:0]        to_IR,
    output logic [7:0]        to_MAR,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              mem_en_n, mem_we_n, busy_n, done_n, err_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n, buffer, buffer_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            buffer    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mem_en    <= mem_en_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            buffer    <= buffer_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        mem_en_n    = mem_en;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        buffer_n    = buffer;
        busy_n      = busy;
        done_n      = 1'b0;
        err_n       = err;
        case (state)
            IDLE: begin
                // Write has priority; a simultaneous read is dropped, not queued.
                if (wr_req) begin
                    mem_addr_n  = addr_in;
                    mem_wdata_n = from_ACC;
                    buffer_n    = from_ACC;
                    mem_en_n    = 1'b1;
                    mem_we_n    = 1'b1;
                    busy_n      = 1'b1;
                    err_n       = 1'b0;
                    cnt_n       = '0;
                    state_n     = WR_WAIT;
                end else if (rd_req) begin
                    mem_addr_n  = addr_in;
                    mem_en_n    = 1'b1;
                    mem_we_n    = 1'b0;
                    busy_n      = 1'b1;
                    err_n       = 1'b0;
                    cnt_n       = '0;
                    state_n     = RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                // Ack is checked before the timeout so a last-cycle ack still succeeds.
                if (mem_ack) begin
                    if (state == RD_WAIT) buffer_n = mem_rdata;
                    mem_en_n = 1'b0;
                    mem_we_n = 1'b0;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end else if (cnt == CNT_LAST) begin
                    err_n    = 1'b1;
                    mem_en_n = 1'b0;
                    mem_we_n = 1'b0;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign to_ALU = buffer;
    assign to_IR  = buffer[15:8];
    assign to_MAR = buffer[7:0];

endmodule

// File: tb/tb_mbr_mem_ctrl.sv
// tb/tb_mbr_mem_ctrl.sv - randomized scoreboard bench for mbr_mem_ctrl
// Driver pushes expected transfer outcomes; a negedge monitor checks bus starts and done pulses.
module tb_mbr_mem_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst, rd_req, wr_req, mem_ack;
    logic [7:0]  addr_in;
    logic [15:0] from_ACC, mem_rdata;
    logic        mem_en, mem_we, busy, done, err;
    logic [7:0]  mem_addr, to_IR, to_MAR;
    logic [15:0] mem_wdata, to_ALU;

    mbr_mem_ctrl #(.DATA_W(16), .ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr_in(addr_in),
        .from_ACC(from_ACC), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .to_ALU(to_ALU), .to_IR(to_IR), .to_MAR(to_MAR), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          en_len;
        logic [15:0] buf_v;
        logic        err_v;
    } exp_t;

    exp_t        q[$];
    logic [15:0] model_buf = '0;
    int          total = 0;
    int          bad = 0;
    int          run_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            run_len = 0;
        end else begin
            if (mem_en === 1'b1) begin
                if (run_len == 0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_start", 32'd1, 32'd0);
                    end else begin
                        chk("start_we", {31'd0, mem_we}, {31'd0, q[0].we});
                        chk("start_addr", {24'd0, mem_addr}, {24'd0, q[0].addr});
                        if (q[0].we) chk("start_wdata", {16'd0, mem_wdata}, {16'd0, q[0].wdata});
                        chk("start_err_clr", {31'd0, err}, 32'd0);
                        chk("start_busy", {31'd0, busy}, 32'd1);
                    end
                end
                run_len++;
            end
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("en_len", run_len, e.en_len);
                    chk("to_ALU", {16'd0, to_ALU}, {16'd0, e.buf_v});
                    chk("to_IR", {24'd0, to_IR}, {24'd0, e.buf_v[15:8]});
                    chk("to_MAR", {24'd0, to_MAR}, {24'd0, e.buf_v[7:0]});
                    chk("err", {31'd0, err}, {31'd0, e.err_v});
                    chk("done_idle", {30'd0, busy, mem_en}, 32'd0);
                end
                run_len = 0;
            end
        end
    end

    // dly >= TIMEOUT means the memory never acknowledges.
    task automatic do_xfer(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [15:0] d, input int dly, input logic [15:0] rdata,
                           input logic spurious);
        exp_t e;
        if (!rd && !wr) return;
        e.we     = wr;
        e.addr   = a;
        e.wdata  = d;
        e.en_len = (dly < TIMEOUT) ? dly + 1 : TIMEOUT;
        e.err_v  = (dly >= TIMEOUT);
        if (wr) model_buf = d;
        else if (dly < TIMEOUT) model_buf = rdata;
        e.buf_v = model_buf;
        q.push_back(e);

        rd_req = rd; wr_req = wr; addr_in = a; from_ACC = d;
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        addr_in = 8'($urandom); from_ACC = 16'($urandom);
        repeat ((dly < TIMEOUT) ? dly : TIMEOUT) begin
            if (spurious) begin
                rd_req = 1'($urandom); wr_req = 1'($urandom);
            end
            tick();
        end
        rd_req = 1'b0; wr_req = 1'b0;
        if (dly < TIMEOUT) begin
            mem_ack = 1'b1; mem_rdata = rdata;
            tick();
            mem_ack = 1'b0; mem_rdata = 16'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0;
        addr_in = '0; from_ACC = '0; mem_rdata = '0;
        tick(); tick();
        chk("rst_outputs", {mem_en, mem_we, busy, done, err, mem_addr, mem_wdata},
            33'd0);
        chk("rst_buffer", {to_ALU, to_IR, to_MAR}, 32'd0);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        tick(); tick();
        mem_ack = 1'b0;
        chk("idle_ack_ignored", {15'd0, to_ALU, mem_en, busy}, 32'd0);

        do_xfer(1'b1, 1'b0, 8'h10, 16'h0000, 2, 16'h1234, 1'b0);
        do_xfer(1'b0, 1'b1, 8'h05, 16'hBEEF, 0, 16'h0000, 1'b0);
        tick();
        do_xfer(1'b1, 1'b0, 8'h22, 16'h0000, TIMEOUT, 16'h0000, 1'b0);
        do_xfer(1'b1, 1'b0, 8'h23, 16'h0000, 0, 16'h5678, 1'b0);
        do_xfer(1'b1, 1'b1, 8'h44, 16'hCAFE, 1, 16'h9999, 1'b0);
        do_xfer(1'b0, 1'b1, 8'h45, 16'hF00D, 4, 16'h0000, 1'b1);
        do_xfer(1'b1, 1'b0, 8'h46, 16'h0000, TIMEOUT - 1, 16'h7E57, 1'b0);
        do_xfer(1'b0, 1'b1, 8'h47, 16'h1357, TIMEOUT + 3, 16'h0000, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int op, dly;
            op = $urandom_range(0, 3);
            case ($urandom_range(0, 7))
                0:       dly = TIMEOUT - 1;
                1:       dly = TIMEOUT;
                default: dly = $urandom_range(0, 5);
            endcase
            do_xfer(op != 1, op == 1 || op == 2, 8'($urandom), 16'($urandom), dly,
                    16'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        // reset during the third RD_WAIT cycle
        tick();
        do_xfer_abort();
        repeat (3) tick();
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic do_xfer_abort();
        exp_t e;
        e.we = 1'b0; e.addr = 8'h33; e.wdata = '0; e.en_len = 0; e.buf_v = '0; e.err_v = 1'b0;
        q.push_back(e);
        rd_req = 1'b1; addr_in = 8'h33;
        tick();
        rd_req = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        q.delete();
        model_buf = '0;
        chk("midrst_idle", {29'd0, mem_en, busy, done}, 32'd0);
        chk("midrst_buffer", {16'd0, to_ALU}, 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_no_done", {30'd0, done, mem_en}, 32'd0);
    endtask

endmodule
